// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: EX-stage <-> mul/div unit handshake and HI/LO read-out
//   master (EX stage): drives start, op, a, b, flush; sees busy, done, hi, lo
//   slave  (unit)    : the reverse
interface mips_muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of mips_muldiv_unit_if
//           start/op/a/b/flush in; busy/done/hi/lo out
module mips_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic                clk,
    input logic                reset,
    mips_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic              is_div_q, is_div_d, dz_q, dz_d, done_q, done_d;
    logic              accept, sgn;
    logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
    logic [XLEN:0]     mul_sum, div_cand, div_diff;
    logic [2*XLEN-1:0] prod;
    // New ops are taken only when idle; a same-cycle flush squashes the start.
    assign accept   = bus.start && !bus.flush && state_q == IDLE;
    assign sgn      = bus.op == 3'd0 || bus.op == 3'd2;
    assign mag_a    = sgn && bus.a[XLEN-1] ? -bus.a : bus.a;
    assign mag_b    = sgn && bus.b[XLEN-1] ? -bus.b : bus.b;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, opnd_q});
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    assign div_cand = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_cand - {1'b0, opnd_q};
    assign prod     = neg_res_q ? -acc_q : acc_q;
    // Zero divisor leaves the remainder equal to |a|, so only LO needs forcing.
    assign quo      = dz_q ? '1 : neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && bus.flush) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:     state_d = !accept ? IDLE : bus.op[2:1] == 2'b00 ? MUL : bus.op[2:1] == 2'b01 ? DIV : IDLE;
                MUL, DIV: state_d = cnt_q == '0 ? FIX : state_q;
                default:  state_d = IDLE;
            endcase
        end
    end
    always_comb begin
        bus.busy = state_q != IDLE;
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        if (accept && !bus.op[2]) begin
            acc_d     = {{XLEN{1'b0}}, mag_a};
            opnd_d    = mag_b;
            cnt_d     = CNT_W'(XLEN - 1);
            neg_res_d = sgn && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_rem_d = sgn && bus.a[XLEN-1];
            is_div_d  = bus.op[1];
            dz_d      = bus.b == '0;
        end
        if (accept && bus.op == 3'd4) hi_d = bus.a;
        if (accept && bus.op == 3'd5) lo_d = bus.a;
        if (state_q == MUL) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
            cnt_d = cnt_q - 1'b1;
        end
        if (state_q == DIV) begin
            acc_d = {div_diff[XLEN] ? div_cand[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], !div_diff[XLEN]};
            cnt_d = cnt_q - 1'b1;
        end
        if (state_q == FIX && !bus.flush) begin
            {hi_d, lo_d} = is_div_q ? {rem, quo} : prod;
            done_d       = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed vectors for mips_muldiv_unit
module tb_mips_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc_ctr = 0;
    int   busy_ctr = 0;
    int   t0 = 0;
    int   b0 = 0;
    int   n_done;
    mips_muldiv_unit_if #(.XLEN(32)) bus ();
    mips_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;
    always @(negedge clk) busy_ctr <= busy_ctr + int'(bus.busy);
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = cyc_ctr;
        b0 = busy_ctr;
    endtask
    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el);
        int n = 0;
        while (!bus.done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(cyc_ctr - t0), 64'd33);
        check({tag, "_busycyc"}, 64'(busy_ctr - b0), 64'd33);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        issue(op, a, b);
        check({tag, "_busy"}, bus.busy, 1);
        wait_done(tag, eh, el);
    endtask
    task automatic load(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.a = h;
        @(posedge clk);
        #1;
        bus.op = 3'd5;
        bus.a = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask
    task automatic quiet(input string tag, input int cycles);
        n_done = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            n_done += int'(bus.done);
        end
        check({tag, "_nodone"}, 64'(n_done), 0);
        check({tag, "_hi"}, bus.hi, 32'h11);
        check({tag, "_lo"}, bus.lo, 32'h22);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b1;
        run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run("div_neg_a", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_neg_b", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("div_zero", 3'd2, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        run("div_zero_neg", 3'd2, 32'hFFFFEDCC, 32'h0, 32'hFFFFEDCC, 32'hFFFFFFFF);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.a = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        check("mthi_hi", bus.hi, 32'hA5A5A5A5);
        check("mthi_busy", bus.busy, 0);
        check("mthi_done", bus.done, 0);
        bus.op = 3'd5;
        bus.a = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h5A5A5A5A);
        check("mtlo_hi", bus.hi, 32'hA5A5A5A5);
        check("mtlo_busy", bus.busy, 0);
        check("mtlo_done", bus.done, 0);
        load(32'h11, 32'h22);
        issue(3'd3, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_mid_busy", bus.busy, 0);
        quiet("flush_mid", 40);
        issue(3'd3, 32'd100, 32'd7);
        repeat (32) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_fix_busy", bus.busy, 0);
        quiet("flush_fix", 40);
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op = 3'd0;
        bus.a = 32'd3;
        bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_busy", bus.busy, 0);
        quiet("start_flush", 40);
        issue(3'd1, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.a = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.op = 3'd2;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ign_hi_kept", bus.hi, 32'h11);
        wait_done("ignored", 32'd0, 32'd12);
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_hi", bus.hi, 0);
        check("arst_lo", bus.lo, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;
        run("mult_after_rst", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative integer multiply/divide unit with architectural HI/LO registers for the MIPS pipelined CPU.
- Sits beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from ID/EX.
- Asserts busy so the hazard detection unit stalls MFHI/MFLO and further mul/div ops.
- Result is committed to HI/LO only on completion, so an in-flight op can be squashed by a branch/jump flush.

Parameters:
- XLEN, 32: operand/result width; HI and LO are each XLEN bits; legal values are even and ≥ 8.
- CNT_W, $clog2(XLEN): iteration counter width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  op valid from the EX stage; sampled on rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
- a  in  XLEN  rs operand (forwarded value).
- b  in  XLEN  rt operand (forwarded value).
- flush  in  1  squash the in-flight op (branch taken / jump).
- busy  out  1  op in progress; hazard unit stalls on it.
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/MULTU/DIV/DIVU.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulators/counter=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start && op∈{0,1}: latch |a| and |b| (magnitudes only for MULT) and the result sign. Go to MUL, counter=XLEN-1, busy=1 from the next cycle.
  - start && op∈{2,3}: latch the same way for DIV, plus the dividend sign. Go to DIV.
  - start && op=4: hi<=a at that edge. Single cycle; busy stays 0; done stays 0.
  - start && op=5: lo<=a at that edge, with the same timing as op=4.
  - op 6/7 or start=0: no change.
- MUL:
  - Radix-2 shift-add, one bit per cycle, 2·XLEN-bit product accumulator.
  - At counter==0 go to FIX; otherwise decrement the counter.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - At counter==0 go to FIX.
- FIX (one cycle):
  - Apply two's-complement sign correction.
  - Commit {hi,lo}: product high/low for multiply; remainder/quotient for divide.
  - Assert done=1 and busy=0 at the same edge, then return to IDLE.
- Latency: start accepted at edge E0; busy high after E0. Commit and done occur at edge E0+XLEN+1. Busy is high for exactly XLEN+1 cycles.
- Signed rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Product is the exact 2·XLEN-bit signed result.
- Divide by zero: lo = all ones, hi = a (dividend unmodified), committed with normal latency and done pulse. Not a trap.
- Signed overflow (DIV of -2^(XLEN-1) by -1): lo = -2^(XLEN-1), hi = 0.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit must not issue it; the unit must not corrupt state.
- flush while busy=1 (MUL/DIV/FIX):
  - Return to IDLE at the next edge; busy=0; done stays 0; hi/lo unchanged.
  - A FIX-cycle flush wins over commit.
- flush and start in the same cycle in IDLE: start is ignored.
- done is a registered single-cycle pulse; it is never high for two consecutive cycles.
- reset asserted mid-operation: immediate abort to the reset values above.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 at E0 -> busy for 33 cycles; at E0+33 hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 for one cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIV cases:
  - a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIV a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A on consecutive cycles -> hi/lo update at each edge; busy and done never assert.
- Squash cases, each starting from hi=0x11 / lo=0x22:
  - DIVU with flush at E0+10 -> busy=0 at E0+11, no done, hi/lo still 0x11/0x22.
  - Repeat with flush in the FIX cycle -> same result.
  - A second start during busy is ignored.
- MULT in progress, reset driven low at E0+5 (asynchronously, mid-cycle) -> hi=lo=0, busy=0 immediately. After reset=1, a new MULT 6×7 -> lo=42, hi=0.
